// File: rtl/xor_arb_ctrl.sv
// xor_arb_ctrl: round-robin front end for two requesters that share one 16-bit adiabatic XOR
// array. It latches the winning operand pair, aligns to the four-phase power clock, waits
// LAT_PER phase periods for evaluation, then holds the result until the consumer takes it.
// Optional feature macro: XOR_ARB_CTRL_IDLE_GATE_EN parks the power clock while idle.
module xor_arb_ctrl #(
    parameter int unsigned LAT_PER = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_id,
    output logic [15:0] xa_a,
    output logic [15:0] xa_b,
    input  logic [15:0] xa_c,
    output logic        clkpos1,
    output logic        clkpos2,
    output logic        clkneg1,
    output logic        clkneg2,
    output logic        busy
);

    // Index of the last EVAL cycle; EVAL always spans whole phase periods.
    localparam logic [3:0] EvalLast = 4'(4 * LAT_PER - 1);

    typedef enum logic [1:0] {StIdle, StAlign, StEval, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [15:0] xa_a_q, xa_a_d;
    logic [15:0] xa_b_q, xa_b_d;
    logic [15:0] resp_data_q, resp_data_d;
    logic        resp_id_q, resp_id_d;
    logic        grant1;
    logic        accept;
    logic        idle;

    assign idle = (state_q == StIdle);

    // Grant: sole valid requester wins; otherwise the one not served last.
    always_comb begin
        grant1 = ~last_q;
        case ({req1_valid, req0_valid})
            2'b01:   grant1 = 1'b0;
            2'b10:   grant1 = 1'b1;
            default: grant1 = ~last_q;
        endcase
    end

    assign req0_ready = idle & ~grant1;
    assign req1_ready = idle & grant1;
    assign accept     = idle & (grant1 ? req1_valid : req0_valid);

    // Next-state logic for the control FSM, phase counter and datapath registers.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q + 2'd1;
        cnt_d       = cnt_q;
        last_d      = last_q;
        xa_a_d      = xa_a_q;
        xa_b_d      = xa_b_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (accept) begin
                    xa_a_d    = grant1 ? req1_a : req0_a;
                    xa_b_d    = grant1 ? req1_b : req0_b;
                    resp_id_d = grant1;
                    last_d    = grant1;
`ifdef XOR_ARB_CTRL_IDLE_GATE_EN
                    // Phase is parked at 0, so evaluation can start straight away.
                    state_d   = StEval;
`else
                    state_d   = (ph_q == 2'd3) ? StEval : StAlign;
`endif
                end
            end
            StAlign: begin
                cnt_d = 4'd0;
                if (ph_q == 2'd3) begin
                    state_d = StEval;
                end
            end
            StEval: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == EvalLast) begin
                    resp_data_d = xa_c;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef XOR_ARB_CTRL_IDLE_GATE_EN
        // Hold phase 0 through IDLE, including the accept cycle.
        if (state_q == StIdle || state_d == StIdle) begin
            ph_d = 2'd0;
        end
`endif
    end

    // State register with asynchronous reset; reset gives requester 0 priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ph_q        <= 2'd0;
            cnt_q       <= 4'd0;
            last_q      <= 1'b1;
            xa_a_q      <= 16'd0;
            xa_b_q      <= 16'd0;
            resp_data_q <= 16'd0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            xa_a_q      <= xa_a_d;
            xa_b_q      <= xa_b_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Power-clock phase decode from the phase counter.
    always_comb begin
        clkpos1 = (ph_q == 2'd0) | (ph_q == 2'd1);
        clkpos2 = (ph_q == 2'd1) | (ph_q == 2'd2);
`ifdef XOR_ARB_CTRL_IDLE_GATE_EN
        if (idle) begin
            clkpos1 = 1'b0;
            clkpos2 = 1'b0;
        end
`endif
        clkneg1 = ~clkpos1;
        clkneg2 = ~clkpos2;
    end

    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign xa_a       = xa_a_q;
    assign xa_b       = xa_b_q;
    assign busy       = ~idle;

endmodule

// File: tb/tb_xor_arb_ctrl.sv
// Self-checking bench for xor_arb_ctrl. Builds with or without XOR_ARB_CTRL_IDLE_GATE_EN.
module tb_xor_arb_ctrl;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_data;
    logic        resp_id;
    logic [15:0] xa_a, xa_b, xa_c;
    logic        clkpos1, clkpos2, clkneg1, clkneg2;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    // Reference free-running phase (meaningful when the power clock is not gated).
    logic [1:0] ph_m;

    always #5 clk = ~clk;

    // Behavioural stand-in for the XOR array.
    assign xa_c = xa_a ^ xa_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph_m <= 2'd0;
        else        ph_m <= ph_m + 2'd1;
    end

    xor_arb_ctrl #(.LAT_PER(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .xa_a       (xa_a),
        .xa_b       (xa_b),
        .xa_c       (xa_c),
        .clkpos1    (clkpos1),
        .clkpos2    (clkpos2),
        .clkneg1    (clkneg1),
        .clkneg2    (clkneg2),
        .busy       (busy)
    );

    // Accept-to-resp_valid latency for an accept made while the phase is p.
    function automatic int exp_lat(input logic [1:0] p);
        int align;
        align = 3 - int'(p);
`ifdef XOR_ARB_CTRL_IDLE_GATE_EN
        align = 0;
`endif
        return 1 + align + 4 * int'(LAT);
    endfunction

    function automatic logic [3:0] exp_phases(input logic [1:0] p, input bit parked);
        logic pos1, pos2;
        pos1 = (p == 2'd0) || (p == 2'd1);
        pos2 = (p == 2'd1) || (p == 2'd2);
        if (parked) return 4'b0011;
        return {pos1, pos2, ~pos1, ~pos2};
    endfunction

    function automatic bit gated();
`ifdef XOR_ARB_CTRL_IDLE_GATE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
    endtask

    // Returns at a falling edge with busy low; checks before stepping.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at a falling edge while idle; presents one request and records the expectation.
    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                         output logic [1:0] p, output logic rdy);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        rdy = id ? req1_ready : req0_ready;
        p   = ph_m;
        sb.push_back({id, a ^ b});
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Starts one cycle after the accept; cycles = accept-to-resp_valid distance.
    task automatic wait_resp(output int cycles, output bit ok, output int rdy_viol);
        cycles   = 1;
        ok       = 1'b0;
        rdy_viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (req0_ready || req1_ready) rdy_viol++;
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ph_exp;
        ph_exp = exp_phases(2'd0, gated());
        @(negedge clk);
        n_checks++;
        if ({busy, resp_valid, resp_id, resp_data, xa_a, xa_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got busy=%b rv=%b id=%b data=%h a=%h b=%h, expected all 0",
                     busy, resp_valid, resp_id, resp_data, xa_a, xa_b);
        end
        n_checks++;
        if ({clkpos1, clkpos2, clkneg1, clkneg2} !== ph_exp) begin
            n_fail++;
            $display("FAIL reset_phases: got %b, expected %b",
                     {clkpos1, clkpos2, clkneg1, clkneg2}, ph_exp);
        end
        n_checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 01", {req1_ready, req0_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        logic rdy;
        logic [1:0] p;
        int cyc, viol;
        exp_t e;
        wait_idle(ok);
        issue(1'b0, 16'hFFFF, 16'h0F0F, p, rdy);
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b, expected 1", rdy);
        end
        wait_resp(cyc, ok, viol);
        n_checks++;
        if (!ok || cyc != exp_lat(p)) begin
            n_fail++;
            $display("FAIL single_latency: got %0d (seen=%0b), expected %0d", cyc, ok, exp_lat(p));
        end
        e = sb.pop_front();
        n_checks++;
        if ({resp_id, resp_data} !== {e.id, e.data}) begin
            n_fail++;
            $display("FAIL single_resp: got id=%b data=%h, expected id=%b data=%h",
                     resp_id, resp_data, e.id, e.data);
        end
        n_checks++;
        if ({xa_a, xa_b} !== {16'hFFFF, 16'h0F0F}) begin
            n_fail++; $display("FAIL single_operands: got %h %h, expected ffff 0f0f", xa_a, xa_b);
        end
        n_checks++;
        if (viol != 0) begin
            n_fail++; $display("FAIL single_ready_busy: got %0d ready cycles, expected 0", viol);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL single_idle: got busy,rv=%b, expected 00", {busy, resp_valid});
        end
    endtask

    task automatic test_align();
`ifndef XOR_ARB_CTRL_IDLE_GATE_EN
        bit ok;
        logic rdy;
        logic [1:0] p;
        logic [4:0] pos1_seen;
        int cyc, viol;
        exp_t e;
        wait_idle(ok);
        for (int i = 0; i < 4 && ph_m != 2'd1; i++) @(negedge clk);
        issue(1'b1, 16'h1234, 16'h00FF, p, rdy);
        n_checks++;
        if ({rdy, p} !== 3'b101) begin
            n_fail++; $display("FAIL align_accept: got rdy=%b ph=%0d, expected rdy=1 ph=1", rdy, p);
        end
        for (int i = 0; i < 5; i++) begin
            pos1_seen[i] = clkpos1;
            if (i < 4) @(negedge clk);
        end
        n_checks++;
        if (pos1_seen !== 5'b01100) begin
            n_fail++;
            $display("FAIL align_clkpos1: got %b, expected 01100 (bit0=first cycle)", pos1_seen);
        end
        wait_resp(cyc, ok, viol);
        n_checks++;
        if (!ok || cyc + 4 != exp_lat(2'd1)) begin
            n_fail++;
            $display("FAIL align_latency: got %0d, expected %0d", cyc + 4, exp_lat(2'd1));
        end
        e = sb.pop_front();
        n_checks++;
        if ({resp_id, resp_data} !== {e.id, e.data}) begin
            n_fail++;
            $display("FAIL align_resp: got id=%b data=%h, expected id=%b data=%h",
                     resp_id, resp_data, e.id, e.data);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_round_robin();
        bit ok;
        int cyc, viol;
        logic [1:0] rdy_seen;
        logic g_exp [3];
        exp_t e;
        g_exp[0] = 1'b0; g_exp[1] = 1'b1; g_exp[2] = 1'b0;
        do_reset();
        req0_a = 16'hA5A5; req0_b = 16'h0FF0;
        req1_a = 16'h1111; req1_b = 16'h2222;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int op = 0; op < 3; op++) begin
            wait_idle(ok);
            #1;
            rdy_seen = {req1_ready, req0_ready};
            n_checks++;
            if (!ok || rdy_seen !== (g_exp[op] ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ready=%b, expected %b", op, rdy_seen,
                         g_exp[op] ? 2'b10 : 2'b01);
            end
            if (g_exp[op]) sb.push_back({1'b1, req1_a ^ req1_b});
            else           sb.push_back({1'b0, req0_a ^ req0_b});
            @(negedge clk);
            if (g_exp[op]) begin req1_a = req1_a + 16'h0301; req1_b = ~req1_b; end
            else           begin req0_a = req0_a ^ 16'hFFFF; req0_b = req0_b + 16'h0101; end
            wait_resp(cyc, ok, viol);
            if (op == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            e = sb.pop_front();
            n_checks++;
            if (!ok || {resp_id, resp_data} !== {e.id, e.data}) begin
                n_fail++;
                $display("FAIL rr_resp%0d: got id=%b data=%h, expected id=%b data=%h",
                         op, resp_id, resp_data, e.id, e.data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic rdy;
        logic [1:0] p;
        int cyc, viol, hold_viol, rdy_viol;
        logic [15:0] d0;
        logic i0;
        exp_t e;
        wait_idle(ok);
        resp_ready = 1'b0;
        issue(1'b1, 16'hBEEF, 16'h5A5A, p, rdy);
        wait_resp(cyc, ok, viol);
        n_checks++;
        if (!ok || rdy !== 1'b1) begin
            n_fail++; $display("FAIL bp_resp_seen: got valid=%b rdy=%b, expected 1 1", ok, rdy);
        end
        d0 = resp_data;
        i0 = resp_id;
        req0_valid = 1'b1;
        req0_a = 16'h7777;
        hold_viol = 0;
        rdy_viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_data !== d0 || resp_id !== i0) hold_viol++;
            if (req0_ready || req1_ready) rdy_viol++;
        end
        resp_ready = 1'b1;
        #1;
        if (req0_ready || req1_ready) rdy_viol++;
        n_checks++;
        if (hold_viol != 0) begin
            n_fail++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", hold_viol);
        end
        n_checks++;
        if (rdy_viol != 0) begin
            n_fail++; $display("FAIL bp_ready: got %0d ready cycles, expected 0", rdy_viol);
        end
        e = sb.pop_front();
        n_checks++;
        if ({i0, d0} !== {e.id, e.data}) begin
            n_fail++;
            $display("FAIL bp_data: got id=%b data=%h, expected id=%b data=%h", i0, d0, e.id, e.data);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL bp_idle_next: got busy,rv=%b, expected 00", {busy, resp_valid});
        end
        req0_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({busy, req1_ready, req0_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_drop_ptr: got busy,ready=%b, expected 001",
                     {busy, req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_eval();
        bit ok;
        logic rdy;
        logic [1:0] p;
        int late;
        wait_idle(ok);
        issue(1'b0, 16'hC3C3, 16'h3C3C, p, rdy);
        repeat (4) @(negedge clk);
        n_checks++;
        if ({busy, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_busy: got busy,rv=%b, expected 10", {busy, resp_valid});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, resp_valid, resp_id, resp_data, xa_a, xa_b} !== '0 ||
            {clkpos1, clkpos2, clkneg1, clkneg2} !== exp_phases(2'd0, gated())) begin
            n_fail++;
            $display("FAIL rst_mid_async: got busy=%b rv=%b data=%h a=%h ph=%b, expected zeros ph=%b",
                     busy, resp_valid, resp_data, xa_a, {clkpos1, clkpos2, clkneg1, clkneg2},
                     exp_phases(2'd0, gated()));
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        late = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid || busy) late++;
        end
        n_checks++;
        if (late != 0) begin
            n_fail++; $display("FAIL rst_mid_no_resp: got %0d active cycles, expected 0", late);
        end
    endtask

    task automatic test_idle_phases();
        logic [3:0] seen, want;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = {clkpos1, clkpos2, clkneg1, clkneg2};
            want = exp_phases(ph_m, gated());
            n_checks++;
            if (busy || seen !== want) begin
                n_fail++;
                $display("FAIL idle_phase%0d: got busy=%b phases=%b, expected busy=0 phases=%b",
                         i, busy, seen, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_align();
        test_round_robin();
        test_backpressure();
        test_reset_mid_eval();
        test_idle_phases();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/xor_arb_ctrl.md
XOR_ARB_CTRL -- requirements
Module: xor_arb_ctrl

Interface
REQ-001 Parameter: LAT_PER, default 1, number of 4-cycle phase periods the 16-bit adiabatic XOR array needs to evaluate (legal 1..4).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operand pair.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operands accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  16  operand pairs.
REQ-007 resp_valid  output  1  result available; resp_ready  input  1  consumer accepts.
REQ-008 resp_data  output  16  XOR result; resp_id  output  1  requester the result belongs to.
REQ-009 xa_a, xa_b  output  16  operand drive to the shared XOR array; xa_c  input  16  array Cout.
REQ-010 clkpos1, clkpos2, clkneg1, clkneg2  output  1  power-clock phase enables to the array.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL have four states: IDLE, ALIGN, EVAL, RESP.
REQ-013 IDLE: exactly one reqN_ready SHALL be high, combinationally, for the granted requester; grant = only valid requester, or, with both valid, the one not granted last (round-robin).
REQ-014 On reqN_valid & reqN_ready, reqN_a/b SHALL be registered into xa_a/xa_b, resp_id set to N, and the FSM SHALL leave IDLE; xa_a/xa_b SHALL hold until the next accept.
REQ-015 A 2-bit phase counter ph SHALL drive clkpos1 = (ph==0|ph==1), clkpos2 = (ph==1|ph==2), clkneg1 = ~clkpos1, clkneg2 = ~clkpos2.
REQ-016 ALIGN: wait until ph==3, then enter EVAL so EVAL's first cycle has ph==0; skip ALIGN when the next ph after accept is already 0.
REQ-017 EVAL SHALL last exactly 4*LAT_PER cycles; on its last cycle xa_c SHALL be registered into resp_data and the FSM SHALL enter RESP.
REQ-018 RESP: resp_valid SHALL be high and resp_data/resp_id stable until resp_valid & resp_ready, then IDLE next cycle.
REQ-019 No reqN_ready SHALL be high outside IDLE; a new request is never accepted in the RESP-handshake cycle.
REQ-020 Dropping reqN_valid before acceptance SHALL be permitted and causes no grant-pointer update.

Reset
REQ-021 rst_n low SHALL immediately force: state IDLE, ph=0, round-robin priority to requester 0, resp_valid=0, resp_data=0, resp_id=0, xa_a=xa_b=0, busy=0, phase outputs per REQ-015/REQ-022 for ph=0.
REQ-022 Reset mid-EVAL or mid-RESP SHALL discard the in-flight operation; no response is produced after release.

Configuration
REQ-023 Macro XOR_ARB_CTRL_IDLE_GATE_EN: when defined, in IDLE ph SHALL be held at 0 and the phase outputs parked (clkpos1=clkpos2=0, clkneg1=clkneg2=1); after accept ALIGN is always skipped and ph restarts at 0 in EVAL.
REQ-024 When XOR_ARB_CTRL_IDLE_GATE_EN is undefined, ph SHALL free-run 0,1,2,3,0 every cycle in all states, including IDLE and RESP.

Verification
REQ-025 Single req0 A=16'hFFFF B=16'h0F0F, macro defined, LAT_PER=1, resp_ready=1: accept cycle T -> resp_valid at T+5, resp_data=16'hF0F0, resp_id=0, busy low at T+6.
REQ-026 req0 and req1 both valid continuously, 3 operations: grants 0,1,0 in order; resp_id sequence 0,1,0, each resp_data = matching A^B.
REQ-027 Macro undefined, accept when ph==1: ALIGN for 2 cycles, EVAL starts at ph==0, clkpos1 high first two EVAL cycles.
REQ-028 resp_ready held low 10 cycles in RESP: resp_valid, resp_data, resp_id constant; both reqN_ready stay 0; after handshake, IDLE next cycle.
REQ-029 rst_n pulsed low during EVAL (LAT_PER=2): all outputs reset asynchronously; no resp_valid after release until a new accept.
REQ-030 Macro defined, idle 8 cycles: clkpos1=clkpos2=0, clkneg1=clkneg2=1 throughout.
